spi_baud_generator_p: RTL and testbench

Parametrised SPI serial-clock generator for the APB-to-SPI bridge, sitting between the APB register block and the SPI shift register. It derives SCLK from PCLK using prescaler fields `sppr_i` and `spr_i`. It issues one-cycle sample/shift strobes for all four CPOL/CPHA modes, counts exactly `2*DATA_W` SCLK edges per slave-select assertion, and then signals frame completion. Low-power wait-mode freeze is supported.

---
 rtl/spi_baud_generator_p.sv | 126 ++++++++++++
 tb/tb_spi_baud_generator_p.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_baud_generator_p.sv
// spi_baud_generator_p: SCLK generator with sample/shift strobes and per-frame edge counting.
// Define SPI_BAUD_SHADOW_EN to freeze sppr/spr/cpol/cpha for the duration of a frame.
module spi_baud_generator_p #(
    parameter int SPPR_W = 3,
    parameter int SPR_W  = 3,
    parameter int DIV_W  = 12,
    parameter int DATA_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        spi_mode_i,
    input  logic              spiswai_i,
    input  logic [SPPR_W-1:0] sppr_i,
    input  logic [SPR_W-1:0]  spr_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              ss_i,
    output logic              sclk_o,
    output logic              miso_receive_sclk0_o,
    output logic              mosi_send_sclk0_o,
    output logic              miso_receive_sclk_o,
    output logic              mosi_send_sclk_o,
    output logic [DIV_W-1:0]  BaudRateDivisor_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int EW = $clog2(2*DATA_W+1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_W-1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, r_div, w_base, w_h, w_d;
    logic [EW-1:0] r_edge;
    logic r_phase, r_arm, r_sclk, r_miso, r_mosi, r_done;
    logic w_en, w_tick, w_sample, w_phase_nxt, w_go;
    logic [SPPR_W-1:0] w_sppr;
    logic [SPR_W-1:0] w_spr;
    logic [SPR_W:0] w_sh;
    logic w_cpol, w_cpha;
`ifdef SPI_BAUD_SHADOW_EN
    logic [SPPR_W-1:0] r_sppr_s;
    logic [SPR_W-1:0] r_spr_s;
    logic r_cpol_s, r_cpha_s;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_sppr_s <= '0;
            r_spr_s  <= '0;
            r_cpol_s <= 1'b0;
            r_cpha_s <= 1'b0;
        end else if (w_go) begin
            r_sppr_s <= sppr_i;
            r_spr_s  <= spr_i;
            r_cpol_s <= cpol_i;
            r_cpha_s <= cpha_i;
        end
    end
    // Idle tracks the live inputs so sclk_o and the divisor stay visible to software.
    assign w_sppr = (r_state == IDLE) ? sppr_i : r_sppr_s;
    assign w_spr  = (r_state == IDLE) ? spr_i  : r_spr_s;
    assign w_cpol = (r_state == IDLE) ? cpol_i : r_cpol_s;
    assign w_cpha = (r_state == IDLE) ? cpha_i : r_cpha_s;
`else
    assign w_sppr = sppr_i;
    assign w_spr  = spr_i;
    assign w_cpol = cpol_i;
    assign w_cpha = cpha_i;
`endif
    assign w_base   = DIV_W'(w_sppr) + DIV_W'(1);
    assign w_sh     = {1'b0, w_spr} + (SPR_W+1)'(1);
    assign w_d      = w_base << w_sh;
    assign w_h      = w_base << w_spr;
    assign w_en     = (spi_mode_i == 2'b00) || (spi_mode_i == 2'b01 && !spiswai_i);
    // >= rather than == so a shrinking divisor never lets the counter run past the compare.
    assign w_tick   = (r_state == RUN) && w_en && !ss_i && (r_cnt >= w_h - DIV_W'(1));
    assign w_sample = (r_edge[0] == w_cpha);
    always_comb begin
        w_state_nxt = r_state;
        if (ss_i || spi_mode_i[1])
            w_state_nxt = IDLE;
        else if (r_state == IDLE && w_en && r_arm)
            w_state_nxt = RUN;
        else if (w_tick && r_edge == LAST_EDGE)
            w_state_nxt = DONE;
        w_go        = (r_state == IDLE) && (w_state_nxt == RUN);
        w_phase_nxt = (w_state_nxt != RUN) ? 1'b0 : (r_phase ^ w_tick);
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_phase <= 1'b0;
            r_arm   <= 1'b1;
            r_sclk  <= 1'b0;
            r_miso  <= 1'b0;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
            r_div   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_d;
            r_arm   <= ss_i || (r_arm && !w_go);
            r_phase <= w_phase_nxt;
            r_sclk  <= w_cpol ^ w_phase_nxt;
            r_miso  <= w_tick && w_sample;
            r_mosi  <= w_tick && !w_sample;
            r_done  <= w_tick && (r_edge == LAST_EDGE);
            if (w_state_nxt != RUN) begin
                r_cnt  <= '0;
                r_edge <= '0;
            end else if (w_tick) begin
                r_cnt  <= '0;
                r_edge <= r_edge + EW'(1);
            end else if (r_state == RUN && w_en) begin
                r_cnt  <= r_cnt + DIV_W'(1);
            end
        end
    end
    assign sclk_o               = r_sclk;
    assign miso_receive_sclk0_o = w_tick && w_sample;
    assign mosi_send_sclk0_o    = w_tick && !w_sample;
    assign miso_receive_sclk_o  = r_miso;
    assign mosi_send_sclk_o     = r_mosi;
    assign BaudRateDivisor_o    = r_div;
    assign busy_o               = (r_state == RUN);
    assign frame_done_o         = r_done;
endmodule

// File: tb/tb_spi_baud_generator_p.sv
// tb_spi_baud_generator_p: divisor vector table plus scoreboarded SCLK edge/strobe sequences.
module tb_spi_baud_generator_p;
    logic clk = 1'b0, rst;
    logic [1:0] mode;
    logic swai, ss, cpol, cpha;
    logic [2:0] sppr, spr;
    logic sclk, miso0, mosi0, miso_r, mosi_r, busy, done;
    logic [11:0] div;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    typedef struct {int cyc; bit sample; bit sclk; bit done;} ev_t;
    typedef struct {logic [2:0] sppr; logic [2:0] spr; int div;} vec_t;
    ev_t q[$];
    vec_t vt[8];
    bit p_miso0, p_mosi0;

    spi_baud_generator_p dut (
        .PCLK(clk), .PRESET(rst), .spi_mode_i(mode), .spiswai_i(swai),
        .sppr_i(sppr), .spr_i(spr), .cpol_i(cpol), .cpha_i(cpha), .ss_i(ss),
        .sclk_o(sclk), .miso_receive_sclk0_o(miso0), .mosi_send_sclk0_o(mosi0),
        .miso_receive_sclk_o(miso_r), .mosi_send_sclk_o(mosi_r),
        .BaudRateDivisor_o(div), .busy_o(busy), .frame_done_o(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic at_cyc(input int m);
        while (cyc < m) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input int lim);
        while (q.size() > 0 && cyc < lim) step(1);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d edges still pending at cycle %0d, expected 0", q.size(), cyc);
            q.delete();
        end
    endtask

    // Edge k ticks in cycle c+k*h (shifted by fl if at/after freeze start fs); its post strobe is one cycle later.
    task automatic push_frame(input int c, input int h, input bit pol, input bit pha,
                              input int n, input int fs, input int fl);
        for (int k = 1; k <= n; k++) begin
            int t;
            t = c + k*h;
            if (fs > 0 && t >= fs) t += fl;
            q.push_back('{cyc: t+1, sample: (((k%2)==1) == !pha), sclk: pol ^ ((k%2)==1), done: (k == 16)});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            p_miso0 = 1'b0;
            p_mosi0 = 1'b0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_edge: got none by cycle %0d, expected strobe at %0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (miso_r || mosi_r) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got miso=%0b mosi=%0b at cycle %0d, expected none", miso_r, mosi_r, cyc);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("edge_cycle", cyc, e.cyc);
                    chk("sample_strobe", miso_r, e.sample);
                    chk("shift_strobe", mosi_r, !e.sample);
                    chk("pre_sample_strobe", p_miso0, e.sample);
                    chk("pre_shift_strobe", p_mosi0, !e.sample);
                    chk("sclk_level", sclk, e.sclk);
                    chk("frame_done", done, e.done);
                end
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done: got 1 at cycle %0d, expected 0", cyc);
            end
            p_miso0 = miso0;
            p_mosi0 = mosi0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int c;
        vt[0] = '{3'd0, 3'd0, 2};
        vt[1] = '{3'd0, 3'd1, 4};
        vt[2] = '{3'd2, 3'd0, 6};
        vt[3] = '{3'd3, 3'd2, 32};
        vt[4] = '{3'd1, 3'd3, 32};
        vt[5] = '{3'd5, 3'd1, 24};
        vt[6] = '{3'd7, 3'd7, 2048};
        vt[7] = '{3'd0, 3'd7, 256};
        rst = 1; ss = 1; mode = 2'b00; swai = 0; sppr = 0; spr = 1; cpol = 0; cpha = 0;
        step(2);
        chk("rst_sclk", sclk, 0);
        chk("rst_pre_strobes", {miso0, mosi0}, 0);
        chk("rst_post_strobes", {miso_r, mosi_r}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div", div, 0);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            sppr = vt[i].sppr;
            spr  = vt[i].spr;
            step(1);
            chk("divisor_table", div, vt[i].div);
        end
        // Mode 0, D=4: full 16-edge frame, then ss held low must not restart.
        sppr = 0; spr = 1; cpol = 0; cpha = 0;
        step(2);
        chk("idle_sclk_cpol0", sclk, 0);
        c = cyc; ss = 0;
        push_frame(c, 2, 0, 0, 16, 0, 0);
        step(1);
        chk("busy_after_ss", busy, 1);
        chk("div_frame_a", div, 4);
        drain(c + 60);
        chk("busy_after_done", busy, 0);
        chk("sclk_after_done", sclk, 0);
        step(40);
        chk("no_second_frame", busy, 0);
        ss = 1; step(2);
        // Mode 3, D=6.
        cpol = 1; cpha = 1; sppr = 2; spr = 0;
        step(2);
        chk("idle_sclk_cpol1", sclk, 1);
        c = cyc; ss = 0;
        push_frame(c, 3, 1, 1, 16, 0, 0);
        drain(c + 80);
        ss = 1; step(2);
        // Largest divisor: first edge after 1024 cycles, then abort.
        cpol = 0; cpha = 0; sppr = 7; spr = 7;
        step(2);
        chk("div_max", div, 2048);
        c = cyc; ss = 0;
        push_frame(c, 1024, 0, 0, 1, 0, 0);
        drain(c + 1100);
        ss = 1; step(2);
        chk("abort_max_busy", busy, 0);
        // Wait-mode freeze of 10 cycles after edge 5.
        sppr = 0; spr = 1;
        step(2);
        c = cyc; ss = 0;
        push_frame(c, 2, 0, 0, 16, c + 12, 10);
        at_cyc(c + 12);
        mode = 2'b01; swai = 1;
        step(5);
        chk("frozen_sclk", sclk, 1);
        chk("frozen_busy", busy, 1);
        at_cyc(c + 22);
        mode = 2'b00; swai = 0;
        drain(c + 80);
        ss = 1; step(2);
        // Abort after edge 5, then a full frame.
        c = cyc; ss = 0;
        push_frame(c, 2, 0, 0, 5, 0, 0);
        at_cyc(c + 11);
        ss = 1;
        step(1);
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_queue_empty", q.size(), 0);
        step(2);
        c = cyc; ss = 0;
        push_frame(c, 2, 0, 0, 16, 0, 0);
        drain(c + 60);
        ss = 1; step(2);
        // spr 1->0 after edge 3.
        c = cyc; ss = 0;
        for (int k = 1; k <= 16; k++) begin
            int t;
`ifdef SPI_BAUD_SHADOW_EN
            t = c + 2*k;
`else
            t = (k <= 3) ? c + 2*k : c + 3 + k;
`endif
            q.push_back('{cyc: t+1, sample: ((k%2)==1), sclk: ((k%2)==1), done: (k == 16)});
        end
        at_cyc(c + 7);
        spr = 0;
        step(1);
`ifdef SPI_BAUD_SHADOW_EN
        chk("div_after_spr_change", div, 4);
`else
        chk("div_after_spr_change", div, 2);
`endif
        drain(c + 60);
        ss = 1; spr = 1; step(2);
        // Asynchronous reset mid-frame.
        c = cyc; ss = 0;
        push_frame(c, 2, 0, 0, 16, 0, 0);
        at_cyc(c + 7);
        #2 rst = 1;
        #1;
        chk("async_rst_sclk", sclk, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_div", div, 0);
        chk("async_rst_strobes", {miso_r, mosi_r, done}, 0);
        q.delete();
        ss = 1;
        step(2);
        rst = 0;
        step(2);
        chk("post_rst_div", div, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
